scroll_frame_gen: RTL and testbench

Upstream stage of the 7x5 multiplexed LED matrix driver. It holds the 35-bit display frame (7 columns x 5 rows) and scrolls it one column left at a fixed rate. New columns enter at column 7 from a column-stream source through a valid/ready handshake. The `frame` output wires one-to-one onto the driver's C1L1..C7L5 pixel inputs.

---
 rtl/scroll_frame_gen_if.sv | 10 +
 rtl/scroll_frame_gen.sv | 108 ++++++++++
 tb/tb_scroll_frame_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/scroll_frame_gen_if.sv
// Column-stream handshake between a column source and scroll_frame_gen.
// The source drives col_data/col_valid; the frame generator answers with col_ready.
interface scroll_frame_gen_if;
  logic [4:0] col_data;
  logic       col_valid;
  logic       col_ready;

  modport master (output col_data, col_valid, input col_ready);
  modport slave  (input col_data, col_valid, output col_ready);
endinterface

// File: rtl/scroll_frame_gen.sv
// 7x5 scrolling frame store: shifts one column left every SCROLL_DIV clocks, new columns enter at column 7.
// Build option SCROLL_WRAP_EN: on a starved tick, recirculate column 1 into column 7 instead of blanking.
//
// state | meaning
// IDLE  | frame waiting for its first column; always ready, divider parked at 0
// RUN   | divider running; a column shifts in on every tick (blank/wrapped if starved)
// HOLD  | paused; divider and frame frozen until pause drops
module scroll_frame_gen #(
  parameter int SCROLL_DIV = 8,
  parameter int CNT_W      = 24
) (
  input  logic                CLK,
  input  logic                RST,
  scroll_frame_gen_if.slave   col,
  input  logic                pause,
  input  logic                clear,
  output logic [34:0]         frame,
  output logic                step_pulse,
  output logic [7:0]          underflow_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(SCROLL_DIV - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick;
  logic             do_shift;
  logic [4:0]       shift_col;
  logic             uf_inc;

  assign tick = (cnt == TICK_VAL);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    col.col_ready = 1'b0;
    do_shift      = 1'b0;
    shift_col     = 5'b0;
    uf_inc        = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          col.col_ready = 1'b1;
          cnt_nxt       = '0;
          if (col.col_valid) begin
            do_shift  = 1'b1;
            shift_col = col.col_data;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = HOLD;
          end else begin
            col.col_ready = tick;
            cnt_nxt       = tick ? '0 : cnt + 1'b1;
            if (tick) begin
              do_shift = 1'b1;
              if (col.col_valid) begin
                shift_col = col.col_data;
              end else begin
`ifdef SCROLL_WRAP_EN
                shift_col = frame[4:0];
`else
                shift_col = 5'b0;
                uf_inc    = 1'b1;
`endif
              end
            end
          end
        end
        HOLD: begin
          if (!pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      frame         <= '0;
      step_pulse    <= 1'b0;
      underflow_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      step_pulse <= do_shift;
      if (clear) begin
        frame <= '0;
      end else if (do_shift) begin
        frame <= {shift_col, frame[34:5]};
      end
      // saturate rather than wrap so a long starvation stays visible
      if (uf_inc && (underflow_cnt != 8'hFF)) begin
        underflow_cnt <= underflow_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_scroll_frame_gen.sv
// Directed bench for scroll_frame_gen (SCROLL_DIV = 4) with a column-array reference model.
// Honours SCROLL_WRAP_EN the same way the design does.
module tb_scroll_frame_gen;
  localparam int DIV = 4;
`ifdef SCROLL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [34:0] frame;
  logic        step_pulse;
  logic [7:0]  underflow_cnt;

  scroll_frame_gen_if sif ();

  scroll_frame_gen #(.SCROLL_DIV(DIV), .CNT_W(3)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .col           (sif.slave),
    .pause         (pause),
    .clear         (clear),
    .frame         (frame),
    .step_pulse    (step_pulse),
    .underflow_cnt (underflow_cnt)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: mode 0=idle 1=running 2=held; elapsed = cycles since last scroll
  int         m_mode = 0;
  int         m_elapsed = 0;
  logic [4:0] m_cols [1:7] = '{default: 5'b0};
  logic       m_step = 1'b0;
  int         m_uf = 0;

  function automatic logic [34:0] model_frame();
    logic [34:0] f;
    f = '0;
    for (int c = 1; c <= 7; c++) f[(c-1)*5 +: 5] = m_cols[c];
    return f;
  endfunction

  function automatic logic model_ready();
    return !clear && ((m_mode == 0) || (m_mode == 1 && !pause && m_elapsed == DIV - 1));
  endfunction

  task automatic model_push(input logic [4:0] nc);
    for (int c = 1; c <= 6; c++) m_cols[c] = m_cols[c+1];
    m_cols[7] = nc;
  endtask

  always @(posedge CLK) begin
    logic [4:0] head;
    if (RST) begin
      m_cols = '{default: 5'b0};
      m_mode = 0; m_elapsed = 0; m_step = 1'b0; m_uf = 0;
    end else begin
      m_step = 1'b0;
      if (clear) begin
        m_cols = '{default: 5'b0};
        m_mode = 0; m_elapsed = 0;
      end else if (m_mode == 0) begin
        if (sif.col_valid) begin
          model_push(sif.col_data); m_step = 1'b1; m_mode = 1; m_elapsed = 0;
        end
      end else if (m_mode == 1) begin
        if (pause) m_mode = 2;
        else if (m_elapsed == DIV - 1) begin
          head = m_cols[1];
          if (sif.col_valid) model_push(sif.col_data);
          else if (WRAP) model_push(head);
          else begin
            model_push(5'b0);
            if (m_uf < 255) m_uf++;
          end
          m_step = 1'b1; m_elapsed = 0;
        end else m_elapsed++;
      end else if (!pause) m_mode = 1;
    end
  end

  always @(negedge CLK) begin
    if (checking) begin
      chk("frame", frame, model_frame());
      chk("col_ready", 35'(sif.col_ready), 35'(model_ready()));
      chk("step_pulse", 35'(step_pulse), 35'(m_step));
      chk("underflow_cnt", 35'(underflow_cnt), 35'(m_uf));
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  logic [34:0] saved;
  int          ones_before;

  initial begin
    sif.col_data = 5'b0;
    sif.col_valid = 1'b0;
    step(); checking = 1'b1; step();
    RST = 1'b0;

    // reset state and first load
    mid();
    chk("reset_frame", frame, 35'd0);
    chk("reset_ready", 35'(sif.col_ready), 35'd1);
    sif.col_valid = 1'b1; sif.col_data = 5'b10101;
    step();
    sif.col_data = 5'h01;
    mid();
    chk("load_col7", 35'(frame[34:30]), 35'h15);
    chk("load_step_pulse", 35'(step_pulse), 35'd1);
    chk("model_load_col7", 35'(model_frame()), {5'h15, 30'd0});

    // steady scroll, one tick every 4 cycles
    for (int k = 1; k <= 3; k++) begin
      repeat (DIV) step();
      sif.col_data = 5'(k + 1);
    end
    sif.col_valid = 1'b0;
    mid();
    chk("scroll_cols", 35'(frame[34:15]), 35'h18835);
    chk("model_scroll_cols", 35'(model_frame()), {20'h18835, 15'd0});

    // starvation across three ticks
    saved = frame;
    ones_before = $countones(saved);
    repeat (3 * DIV) step();
    mid();
    if (WRAP) begin
      chk("wrap_popcount", 35'($countones(frame)), 35'(ones_before));
      chk("wrap_uf", 35'(underflow_cnt), 35'd0);
    end else begin
      chk("underflow_cols", 35'(frame[34:20]), 35'd0);
      chk("underflow_cnt3", 35'(underflow_cnt), 35'd3);
    end

    // pause landing on the tick cycle
    repeat (DIV - 1) step();
    pause = 1'b1; sif.col_valid = 1'b1; sif.col_data = 5'h1F;
    mid();
    chk("pause_tick_ready", 35'(sif.col_ready), 35'd0);
    saved = frame;
    repeat (10) step();
    mid();
    chk("pause_frozen", frame, saved);
    pause = 1'b0;
    step();
    mid();
    chk("resume_tick_ready", 35'(sif.col_ready), 35'd1);
    step();
    sif.col_valid = 1'b0;
    mid();
    chk("resume_shift", 35'(frame[34:30]), 35'h1F);
    chk("resume_pulse", 35'(step_pulse), 35'd1);

    // clear mid-run after two more starved ticks
    repeat (2 * DIV) step();
    clear = 1'b1;
    mid();
    chk("clear_cycle_ready", 35'(sif.col_ready), 35'd0);
    step();
    clear = 1'b0;
    mid();
    chk("clear_frame", frame, 35'd0);
    chk("clear_ready", 35'(sif.col_ready), 35'd1);
    chk("clear_uf_kept", 35'(underflow_cnt), WRAP ? 35'd0 : 35'd5);

    // clear together with pause lands in IDLE, not HOLD
    sif.col_valid = 1'b1; sif.col_data = 5'h07;
    step();
    sif.col_valid = 1'b0;
    repeat (2) step();
    clear = 1'b1; pause = 1'b1;
    step();
    clear = 1'b0;
    mid();
    chk("clear_pause_idle", 35'(sif.col_ready), 35'd1);
    step();
    mid();
    chk("idle_ignores_pause", 35'(sif.col_ready), 35'd1);
    pause = 1'b0;

    // long starvation saturates the counter
    sif.col_valid = 1'b1; sif.col_data = 5'h0A;
    step();
    sif.col_valid = 1'b0;
    repeat (260 * DIV) step();
    mid();
    chk("uf_saturate", 35'(underflow_cnt), WRAP ? 35'd0 : 35'd255);

    // reset while held with a non-zero frame
    clear = 1'b1;
    step();
    clear = 1'b0;
    sif.col_valid = 1'b1; sif.col_data = 5'h0A;
    step();
    sif.col_valid = 1'b0;
    step();
    pause = 1'b1;
    repeat (3) step();
    mid();
    chk("hold_frame", frame, {5'h0A, 30'd0});
    RST = 1'b1;
    step();
    RST = 1'b0; pause = 1'b0;
    mid();
    chk("rst_frame", frame, 35'd0);
    chk("rst_uf", 35'(underflow_cnt), 35'd0);
    chk("rst_pulse", 35'(step_pulse), 35'd0);
    chk("rst_idle_ready", 35'(sif.col_ready), 35'd1);
    repeat (3) step();

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
